// File: rtl/cfg_pkg.sv
// Shared constants and state encoding for the configuration loader and the fabric top.
package cfg_pkg;

  localparam int N_TILES   = 16;
  localparam int TILE_BITS = 33;
  localparam int ADDR_W    = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    HUNT,
    COUNT,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/cfg_chk_accum.sv
// Byte-lane XOR checksum: bit k of chk is the XOR of every payload bit at stream position k mod 8.
module cfg_chk_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [7:0] chk
);

  logic [2:0] p;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      p   <= 3'd0;
      chk <= 8'd0;
    end else if (en) begin
      chk[p] <= chk[p] ^ din;
      p      <= p + 3'd1;
    end
  end

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Serial bitstream loader: sync hunt, tile count, per-tile frames written in parallel, checksum gate.
module cfg_bitstream_loader
  import cfg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_ready,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [TILE_BITS-1:0] wr_data,
  output logic                 cfg_done,
  output logic                 cfg_error,
  output logic                 fabric_rst
);

  localparam logic [7:0] MAX_CNT       = 8'(N_TILES);
  localparam logic [5:0] LAST_FRAME_IX = 6'(TILE_BITS - 1);

  state_t state, next_state;

  logic [7:0]           sync_sr;
  logic [7:0]           cnt;
  logic [7:0]           rx;
  logic [TILE_BITS-1:0] frame;
  logic [5:0]           bit_cnt;
  logic [ADDR_W-1:0]    tile_idx;
  logic [7:0]           chk;

  logic                 accept;
  logic                 last_byte_bit;
  logic                 last_frame_bit;
  logic                 last_tile;
  logic [7:0]           sr_next;
  logic [7:0]           cnt_next;
  logic [7:0]           rx_next;
  logic [TILE_BITS-1:0] frame_next;
  logic                 chk_clear;
  logic                 chk_en;

  // Every field arrives LSB first, so all shifters take the new bit in at the MSB.
  assign sr_next        = {cfg_bit, sync_sr[7:1]};
  assign cnt_next       = {cfg_bit, cnt[7:1]};
  assign rx_next        = {cfg_bit, rx[7:1]};
  assign frame_next     = {cfg_bit, frame[TILE_BITS-1:1]};
  assign accept         = cfg_valid & cfg_ready;
  assign last_byte_bit  = (bit_cnt == 6'd7);
  assign last_frame_bit = (bit_cnt == LAST_FRAME_IX);
  assign last_tile      = ({{(8-ADDR_W){1'b0}}, tile_idx} == (cnt - 8'd1));

  cfg_chk_accum u_chk (
    .clk   (clk),
    .rst   (rst),
    .clear (chk_clear),
    .en    (chk_en),
    .din   (cfg_bit),
    .chk   (chk)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    cfg_ready  = 1'b1;
    cfg_done   = 1'b0;
    cfg_error  = 1'b0;
    fabric_rst = 1'b1;
    chk_clear  = 1'b0;
    chk_en     = 1'b0;
    case (state)
      HUNT: begin
        chk_clear = 1'b1;
        if (accept && (sr_next == SYNC)) next_state = COUNT;
      end
      COUNT: begin
        chk_en = accept;
        if (accept && last_byte_bit) begin
          if ((cnt_next == 8'd0) || (cnt_next > MAX_CNT)) next_state = ERROR;
          else                                            next_state = LOAD;
        end
      end
      LOAD: begin
        chk_en = accept;
        if (accept && last_frame_bit && last_tile) next_state = CHECK;
      end
      CHECK: begin
        if (accept && last_byte_bit) begin
          if (rx_next == chk) next_state = DONE;
          else                next_state = ERROR;
        end
      end
      DONE: begin
        cfg_ready  = 1'b0;
        cfg_done   = 1'b1;
        fabric_rst = 1'b0;
      end
      ERROR: begin
        cfg_ready = 1'b0;
        cfg_error = 1'b1;
      end
      default: next_state = HUNT;
    endcase
  end

  // The write strobe is a registered one-cycle pulse; bit intake never stalls for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_sr  <= 8'd0;
      cnt      <= 8'd0;
      rx       <= 8'd0;
      frame    <= '0;
      bit_cnt  <= 6'd0;
      tile_idx <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (accept) begin
        case (state)
          HUNT: begin
            sync_sr <= sr_next;
            bit_cnt <= 6'd0;
          end
          COUNT: begin
            cnt      <= cnt_next;
            tile_idx <= '0;
            bit_cnt  <= last_byte_bit ? 6'd0 : bit_cnt + 6'd1;
          end
          LOAD: begin
            frame <= frame_next;
            if (last_frame_bit) begin
              bit_cnt  <= 6'd0;
              wr_en    <= 1'b1;
              wr_data  <= frame_next;
              wr_addr  <= tile_idx;
              tile_idx <= tile_idx + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          CHECK: begin
            rx      <= rx_next;
            bit_cnt <= last_byte_bit ? 6'd0 : bit_cnt + 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Directed self-checking bench for cfg_bitstream_loader.
module tb_cfg_bitstream_loader;
  import cfg_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_valid;
  logic                 cfg_bit;
  logic                 cfg_ready;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [TILE_BITS-1:0] wr_data;
  logic                 cfg_done;
  logic                 cfg_error;
  logic                 fabric_rst;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit gap_en   = 1'b0;

  logic [7:0] m_chk;
  logic [2:0] m_p;

  logic [ADDR_W-1:0]    log_addr[$];
  logic [TILE_BITS-1:0] log_data[$];
  int                   log_cyc[$];

  cfg_bitstream_loader dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .cfg_ready  (cfg_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cfg_done   (cfg_done),
    .cfg_error  (cfg_error),
    .fabric_rst (fabric_rst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  // Optional random idle cycles model a source that stalls about half the time.
  task automatic send_bit(input logic b);
    if (gap_en) begin
      for (int k = 0; k < 4 && $urandom_range(1, 0) == 1; k++) begin
        cfg_valid = 1'b0;
        @(negedge clk);
      end
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_payload_bit(input logic b);
    m_chk[m_p] = m_chk[m_p] ^ b;
    m_p        = m_p + 3'd1;
    send_bit(b);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 8; i++) send_bit(SYNC[i]);
    m_chk = 8'd0;
    m_p   = 3'd0;
  endtask

  task automatic send_count(input logic [7:0] c);
    for (int i = 0; i < 8; i++) send_payload_bit(c[i]);
  endtask

  task automatic send_frame(input logic [TILE_BITS-1:0] f);
    for (int i = 0; i < TILE_BITS; i++) send_payload_bit(f[i]);
  endtask

  task automatic send_check_first7(input logic [7:0] c);
    for (int i = 0; i < 7; i++) send_bit(c[i]);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cfg_ready, wr_en, cfg_done, cfg_error, fabric_rst} !== 5'b10001) begin
      n_fail++;
      $display("FAIL reset_flags: got ready/wr/done/err/frst=%b expected 10001",
               {cfg_ready, wr_en, cfg_done, cfg_error, fabric_rst});
    end
    n_checks++;
    if (wr_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_wr_bus: got addr=%0h data=%0h expected 0/0", wr_addr, wr_data);
    end
    n_checks++;
    if (dut.state !== HUNT) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected HUNT", dut.state);
    end
    rst = 1'b0;
    clear_log();
  endtask

  // Garbage bits, sync, one tile, checksum 8'h01 worked out by hand.
  task automatic run_single(input string name);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_sync();
    send_count(8'h01);
    send_frame(33'h1_0000_0001);
    send_check_first7(8'h01);
    n_checks++;
    if (cfg_done !== 1'b0 || fabric_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_early_done: got done=%b frst=%b expected 0/1", name, cfg_done, fabric_rst);
    end
    send_bit(1'b0);
    n_checks++;
    if (log_addr.size() !== 1) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d expected 1", name, log_addr.size());
    end else begin
      n_checks++;
      if (log_addr[0] !== 4'd0 || log_data[0] !== 33'h1_0000_0001) begin
        n_fail++;
        $display("FAIL %s_write: got addr=%0h data=%0h expected 0/100000001",
                 name, log_addr[0], log_data[0]);
      end
    end
    n_checks++;
    if ({cfg_done, cfg_error, fabric_rst, cfg_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s_done: got done/err/frst/ready=%b expected 1000",
               name, {cfg_done, cfg_error, fabric_rst, cfg_ready});
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_single("basic");
  endtask

  task automatic test_bad_count();
    logic [7:0] bad[2];
    bad[0] = 8'h00;
    bad[1] = 8'(N_TILES + 1);
    for (int t = 0; t < 2; t++) begin
      do_reset();
      send_sync();
      send_count(bad[t]);
      n_checks++;
      if ({cfg_error, cfg_ready, fabric_rst, cfg_done} !== 4'b1010) begin
        n_fail++;
        $display("FAIL bad_count_%0h: got err/ready/frst/done=%b expected 1010",
                 bad[t], {cfg_error, cfg_ready, fabric_rst, cfg_done});
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (log_addr.size() !== 0 || cfg_error !== 1'b1) begin
        n_fail++;
        $display("FAIL bad_count_%0h_sticky: got writes=%0d err=%b expected 0/1",
                 bad[t], log_addr.size(), cfg_error);
      end
    end
  endtask

  task automatic test_bad_checksum();
    logic [TILE_BITS-1:0] fr[3];
    logic [7:0]           bad_chk;
    fr[0] = 33'h0_DEAD_BEEF;
    fr[1] = 33'h1_1234_5678;
    fr[2] = 33'h0_0F0F_00FF;
    do_reset();
    send_sync();
    send_count(8'd3);
    for (int i = 0; i < 3; i++) send_frame(fr[i]);
    bad_chk = m_chk ^ 8'h80;
    for (int i = 0; i < 8; i++) send_bit(bad_chk[i]);
    n_checks++;
    if (log_addr.size() !== 3) begin
      n_fail++;
      $display("FAIL badchk_write_count: got %0d expected 3", log_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== fr[i]) begin
          n_fail++;
          $display("FAIL badchk_write%0d: got addr=%0h data=%0h expected %0h/%0h",
                   i, log_addr[i], log_data[i], i, fr[i]);
        end
      end
    end
    n_checks++;
    if ({cfg_error, cfg_done, fabric_rst, cfg_ready} !== 4'b1010) begin
      n_fail++;
      $display("FAIL badchk_error: got err/done/frst/ready=%b expected 1010",
               {cfg_error, cfg_done, fabric_rst, cfg_ready});
    end
  endtask

  task automatic test_gaps();
    do_reset();
    gap_en = 1'b1;
    run_single("gaps");
    gap_en = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [TILE_BITS-1:0] f1;
    f1 = 33'h0_CAFE_F00D;
    do_reset();
    send_sync();
    send_count(8'd2);
    send_frame(33'h1_5555_AAAA);
    for (int i = 0; i < 19; i++) send_payload_bit(f1[i]);
    rst       = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = f1[19];
    @(negedge clk);
    cfg_valid = 1'b0;
    n_checks++;
    if (dut.state !== HUNT) begin
      n_fail++;
      $display("FAIL midrst_state: got %0d expected HUNT", dut.state);
    end
    n_checks++;
    if ({cfg_ready, wr_en, cfg_done, cfg_error, fabric_rst} !== 5'b10001 ||
        wr_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got flags=%b addr=%0h data=%0h expected 10001/0/0",
               {cfg_ready, wr_en, cfg_done, cfg_error, fabric_rst}, wr_addr, wr_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (log_addr.size() !== 1) begin
      n_fail++;
      $display("FAIL midrst_writes: got %0d expected 1", log_addr.size());
    end
    clear_log();
    run_single("after_midrst");
  endtask

  // All-ones frames put 66 ones in each lane, so only the count 8'h10 survives in the checksum.
  task automatic test_back_to_back();
    do_reset();
    send_sync();
    send_count(8'(N_TILES));
    for (int i = 0; i < N_TILES; i++) send_frame(33'h1_FFFF_FFFF);
    for (int i = 0; i < 8; i++) send_bit(i == 4 ? 1'b1 : 1'b0);
    n_checks++;
    if (log_addr.size() !== N_TILES) begin
      n_fail++;
      $display("FAIL b2b_write_count: got %0d expected %0d", log_addr.size(), N_TILES);
    end else begin
      for (int i = 0; i < N_TILES; i++) begin
        n_checks++;
        if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== 33'h1_FFFF_FFFF ||
            (i > 0 && (log_cyc[i] - log_cyc[i-1]) != TILE_BITS)) begin
          n_fail++;
          $display("FAIL b2b_write%0d: got addr=%0h data=%0h spacing=%0d expected %0h/1ffffffff/%0d",
                   i, log_addr[i], log_data[i], (i > 0) ? log_cyc[i] - log_cyc[i-1] : TILE_BITS,
                   i, TILE_BITS);
        end
      end
    end
    n_checks++;
    if ({cfg_done, cfg_error, fabric_rst} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_done: got done/err/frst=%b expected 100",
               {cfg_done, cfg_error, fabric_rst});
    end
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    m_chk     = 8'd0;
    m_p       = 3'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_count();
    test_bad_checksum();
    test_gaps();
    test_reset_mid_load();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
